// File: rtl/fp_mul_norm_round_pipe.sv
`timescale 1ns/1ps
// Normalise/round/pack back end of the FP multiplier: S1 normalises the raw product, S2 rounds and packs.
// Define FPN_RNE_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
module fp_mul_norm_round_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W+1:0]       in_exp,
    input  logic [2*MAN_W+1:0]     in_prod,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_overflow,
    output logic                   out_underflow,
    output logic                   out_inexact,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};

    logic                   r_s1_valid;
    logic                   r_s1_sign;
    logic signed [EW-1:0]   r_s1_exp;
    logic [MAN_W-1:0]       r_s1_mant;
    logic                   r_s1_guard;
    logic                   r_s1_sticky;
    logic                   r_s1_zero;
    logic [TAG_W-1:0]       r_s1_tag;

    logic                   r_out_valid;
    logic [EXP_W+MAN_W:0]   r_out_result;
    logic                   r_out_overflow;
    logic                   r_out_underflow;
    logic                   r_out_inexact;
    logic [TAG_W-1:0]       r_out_tag;

    logic                   w_s2_adv;
    logic                   w_s1_adv;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    logic                   w_n_zero;
    logic signed [EW-1:0]   w_n_exp;
    logic [MAN_W-1:0]       w_n_mant;
    logic                   w_n_guard;
    logic                   w_n_sticky;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_n_zero   = (in_prod == '0);
        w_n_exp    = in_exp;
        w_n_mant   = in_prod[2*MAN_W-1:MAN_W];
        w_n_guard  = in_prod[MAN_W-1];
        w_n_sticky = |in_prod[MAN_W-2:0];
        if (in_prod[2*MAN_W+1]) begin
            w_n_exp    = in_exp + EW'(1);
            w_n_mant   = in_prod[2*MAN_W:MAN_W+1];
            w_n_guard  = in_prod[MAN_W];
            w_n_sticky = |in_prod[MAN_W-1:0];
        end
    end

    logic                   w_inc;
    logic [MAN_W:0]         w_sum;
    logic [MAN_W-1:0]       w_r_mant;
    logic signed [EW-1:0]   w_r_exp;
    logic [EXP_W+MAN_W:0]   w_result;
    logic                   w_overflow;
    logic                   w_underflow;
    logic                   w_inexact;

`ifdef FPN_RNE_EN
    assign w_inc = r_s1_guard & (r_s1_sticky | r_s1_mant[0]);
`else
    assign w_inc = 1'b0;
`endif

    // A carry out of the mantissa means it rolled over to 1.0 of the next binade.
    assign w_sum    = {1'b0, r_s1_mant} + (MAN_W+1)'(w_inc);
    assign w_r_mant = w_sum[MAN_W] ? '0 : w_sum[MAN_W-1:0];
    assign w_r_exp  = r_s1_exp + EW'(w_sum[MAN_W]);

    always_comb begin
        w_result    = {r_s1_sign, w_r_exp[EXP_W-1:0], w_r_mant};
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_inexact   = r_s1_guard | r_s1_sticky;
        if (r_s1_zero) begin
            w_result  = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_inexact = 1'b0;
        end else if (w_r_exp >= EXP_MAX) begin
            w_result   = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_overflow = 1'b1;
            w_inexact  = 1'b1;
        end else if (w_r_exp[EW-1] || (w_r_exp == '0)) begin
            w_result    = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_underflow = 1'b1;
            w_inexact   = 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so both stages shift on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid      <= 1'b0;
            r_s1_sign       <= 1'b0;
            r_s1_exp        <= '0;
            r_s1_mant       <= '0;
            r_s1_guard      <= 1'b0;
            r_s1_sticky     <= 1'b0;
            r_s1_zero       <= 1'b0;
            r_s1_tag        <= '0;
            r_out_valid     <= 1'b0;
            r_out_result    <= '0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_inexact   <= 1'b0;
            r_out_tag       <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_sign   <= in_sign;
                    r_s1_exp    <= w_n_exp;
                    r_s1_mant   <= w_n_mant;
                    r_s1_guard  <= w_n_guard;
                    r_s1_sticky <= w_n_sticky;
                    r_s1_zero   <= w_n_zero;
                    r_s1_tag    <= in_tag;
                end
            end
            // Output registers only load on a real beat, so a stalled result stays put.
            if (w_s2_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_result    <= w_result;
                    r_out_overflow  <= w_overflow;
                    r_out_underflow <= w_underflow;
                    r_out_inexact   <= w_inexact;
                    r_out_tag       <= r_s1_tag;
                end
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_overflow  = r_out_overflow;
    assign out_underflow = r_out_underflow;
    assign out_inexact   = r_out_inexact;
    assign out_tag       = r_out_tag;

endmodule
